// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs R/I/J field sets into 32-bit words,
// tags each legal word with a running byte address and buffers it in a
// 2-entry FIFO. Illegal field sets are consumed and counted, never emitted.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  fmt,
   input  logic [5:0]  opcode,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] immediate,
   input  logic [25:0] target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic [31:0] addr,
   output logic [1:0]  level,
   output logic        err_flag,
   output logic [7:0]  err_count
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } entry_t;

   // Slot 0 is always the head; slot 1 holds the second word when level=2.
   entry_t [1:0] ent_q, ent_d;
   logic [1:0]   level_q, level_d;
   logic [31:0]  addr_cnt_q, addr_cnt_d;
   logic         err_flag_q, err_flag_d;
   logic [7:0]   err_count_q, err_count_d;

   logic [31:0]  word;
   logic         legal;
   logic         push, pop, wr;
   entry_t       new_ent;

   // Encode the selected format and decide legality from fmt/opcode only.
   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (fmt)
         2'd0: begin
            word  = {opcode, rs, rt, rd, shamt, funct};
            legal = (opcode == 6'd0);
         end
         2'd1: begin
            word  = {opcode, rs, rt, immediate};
            legal = (opcode != 6'd0) && (opcode != 6'd2) && (opcode != 6'd3);
         end
         2'd2: begin
            word  = {opcode, target};
            legal = (opcode == 6'd2) || (opcode == 6'd3);
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

   // in_ready depends only on registered occupancy, so out_ready never reaches it.
   assign in_ready  = (level_q != 2'd2);
   assign out_valid = (level_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign wr        = push && legal;
   assign new_ent   = '{instr: word, addr: addr_cnt_q};

   // Next-state for FIFO slots, occupancy, address counter and error state.
   always_comb begin
      ent_d       = ent_q;
      level_d     = level_q;
      addr_cnt_d  = addr_cnt_q;
      err_flag_d  = err_flag_q;
      err_count_d = err_count_q;
      case ({wr, pop})
         2'b10: begin
            ent_d[level_q[0]] = new_ent;
            level_d           = level_q + 2'd1;
         end
         2'b01: begin
            ent_d[0] = ent_q[1];
            level_d  = level_q - 2'd1;
         end
         2'b11: begin
            // Only reachable at level 1: head leaves, new word becomes head.
            ent_d[0] = new_ent;
         end
         default: ;
      endcase
      if (wr)
         addr_cnt_d = addr_cnt_q + 32'd4;
      if (push && !legal) begin
         err_flag_d = 1'b1;
         if (err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
      end
   end

   // State registers; reset wins over any simultaneous push or pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_q       <= '0;
         level_q     <= 2'd0;
         addr_cnt_q  <= BASE_ADDR;
         err_flag_q  <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         ent_q       <= ent_d;
         level_q     <= level_d;
         addr_cnt_q  <= addr_cnt_d;
         err_flag_q  <= err_flag_d;
         err_count_q <= err_count_d;
      end
   end

   assign instr     = ent_q[0].instr;
   assign addr      = ent_q[0].addr;
   assign level     = level_q;
   assign err_flag  = err_flag_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field sets push expected
// {instr,addr} pairs into a queue; a negedge monitor pops and compares
// every word the DUT hands over.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [1:0]  fmt;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] immediate;
   logic [25:0] target;
   logic        out_valid, out_ready;
   logic [31:0] instr, addr;
   logic [1:0]  level;
   logic        err_flag;
   logic [7:0]  err_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_addr;

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .immediate(immediate), .target(target),
      .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
      .level(level), .err_flag(err_flag), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a word is handed over on the edge after this sample.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_word: got %h@%h expected none", instr, addr);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            chk("word_instr", instr, e[63:32]);
            chk("word_addr", addr, e[31:0]);
         end
      end
   end

   task automatic apply(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
      fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
      immediate = im; target = tg; in_valid = 1'b1;
   endtask

   // Wait (bounded) for acceptance of the applied field set, then log expectation.
   task automatic accept(input bit legal, input logic [31:0] exp_word);
      int tries = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         tries++;
         if (tries > 20) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (legal) begin
         sb_q.push_back({exp_word, exp_addr});
         exp_addr += 32'd4;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      sb_q.delete();
      exp_addr = BASE;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drain_queue_empty", sb_q.size(), 0);
   endtask

   task automatic chk_reset_state();
      chk("rst_level", level, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_instr", instr, 0);
      chk("rst_addr", addr, 0);
      chk("rst_err_flag", err_flag, 0);
      chk("rst_err_count", err_count, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      apply(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      exp_addr = BASE;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      rst_n = 1'b1;

      // R push with out_ready=1: valid one cycle after the push edge.
      out_ready = 1'b1;
      apply(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'hFFFF, 26'h3FFFFFF);
      accept(1, 32'h0022_1905);
      chk("latency_out_valid", out_valid, 1);
      drain();

      // Fill to level 2, hold off a third word, then release in order.
      do_reset();
      out_ready = 1'b0;
      apply(2'd1, 6'd35, 5'd1, 5'd2, 5'd31, 5'd31, 6'd63, 16'd3, 26'd0);
      accept(1, 32'h8C22_0003);
      apply(2'd2, 6'd2, 5'd9, 5'd9, 5'd9, 5'd9, 6'd9, 16'd9, 26'd3);
      accept(1, 32'h0800_0003);
      apply(2'd0, 6'd0, 5'd7, 5'd8, 5'd9, 5'd0, 6'h20, 16'd0, 26'd0);
      repeat (3) begin
         @(negedge clk);
         chk("full_level", level, 2);
         chk("full_in_ready", in_ready, 0);
         chk("full_instr_stable", instr, 32'h8C22_0003);
      end
      out_ready = 1'b1;
      accept(1, 32'h00E8_4820);
      drain();

      // Illegal R (opcode 35): consumed, counted, address not advanced.
      apply(2'd0, 6'd35, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd0, 26'd0);
      accept(0, 32'd0);
      chk("illegal_err_flag", err_flag, 1);
      chk("illegal_err_count", err_count, 1);
      chk("illegal_level", level, 0);
      apply(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h123456);
      accept(1, 32'h0C12_3456);
      drain();

      // Simultaneous push and pop at level 1.
      out_ready = 1'b0;
      apply(2'd1, 6'd8, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
      accept(1, 32'h2085_1234);
      chk("pp_level_before", level, 1);
      out_ready = 1'b1;
      apply(2'd1, 6'd13, 5'd6, 5'd7, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
      accept(1, 32'h34C7_BEEF);
      chk("pp_level_after", level, 1);
      drain();

      // Reset with a full buffer and a raised error flag.
      out_ready = 1'b0;
      apply(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      accept(0, 32'd0);
      apply(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd1);
      accept(1, 32'h0800_0001);
      apply(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd2);
      accept(1, 32'h0800_0002);
      chk("prerst_level", level, 2);
      chk("prerst_err_flag", err_flag, 1);
      do_reset();
      chk_reset_state();
      out_ready = 1'b1;
      apply(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd0, 26'd0);
      accept(1, 32'h0022_1905);
      drain();

      // Saturating error counter with one word parked in the buffer.
      out_ready = 1'b0;
      apply(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd7);
      accept(1, 32'h0C00_0007);
      apply(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      repeat (254) @(posedge clk);
      #1;
      chk("sat_count_254", err_count, 254);
      @(posedge clk); #1;
      chk("sat_count_255", err_count, 255);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("sat_count_256", err_count, 255);
      chk("sat_err_flag", err_flag, 1);
      chk("sat_level", level, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
